// File: rtl/vga_line_prefetch.sv
// Ping-pong VGA line buffer. The display reads line y from one bank while line y+1 is fetched into the other bank.
// Latency: rgb is registered, 1 cycle after x_coord/y_coord. A fetch takes one command plus BURST_WORDS pops per burst.
// Backpressure: waits in CMD while mem_cmd_full is high. Pops only while mem_rd_empty is low. Aborts after WAIT_TIMEOUT idle cycles.
// Ports: clk/reset; calib_done gates new fetches; x_coord/y_coord/line_start come from the timing controller;
//   rgb is the pixel; underflow/overrun/timeout_err are sticky; mem_cmd_* and mem_rd_* form the memory read port.
module vga_line_prefetch #(
  parameter int                        X_BITS       = 8,
  parameter int                        Y_BITS       = 8,
  parameter int                        SCREEN_LINES = 192,
  parameter int                        BURST_WORDS  = 64,
  parameter logic [29-Y_BITS-X_BITS:0] GFX_PREFIX   = '0,
  parameter int                        WAIT_TIMEOUT = 100,
  parameter logic [7:0]                BLANK_COLOR  = 8'h00
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              calib_done,
  input  logic [X_BITS-1:0] x_coord,
  input  logic [Y_BITS-1:0] y_coord,
  input  logic              line_start,
  output logic [7:0]        rgb,
  output logic              underflow,
  output logic              overrun,
  output logic              timeout_err,
  output logic              mem_cmd_en,
  output logic [2:0]        mem_cmd_instr,
  output logic [5:0]        mem_cmd_bl,
  output logic [29:0]       mem_cmd_byte_addr,
  input  logic              mem_cmd_full,
  output logic              mem_rd_en,
  input  logic [31:0]       mem_rd_data,
  input  logic              mem_rd_empty
);

  localparam int LINE_PIXELS = 2 ** X_BITS;
  localparam int LINE_WORDS  = LINE_PIXELS / 4;
  localparam int NUM_BURSTS  = LINE_WORDS / BURST_WORDS;
  localparam int BI_W        = (NUM_BURSTS > 1) ? $clog2(NUM_BURSTS) : 1;
  localparam int WC_W        = X_BITS - 2;
  localparam int T_W         = $clog2(WAIT_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, FLUSH, CMD, READ} state_t;

  state_t            state, state_n;
  logic [1:0]        bank_valid;
  logic [Y_BITS-1:0] y_fetch;
  logic [BI_W-1:0]   burst_idx;
  logic [WC_W-1:0]   word_cnt;
  logic [5:0]        beat_cnt;
  logic [T_W-1:0]    timer;
  logic [7:0]        ram [0:1][0:LINE_PIXELS-1];

  logic              start_ok;
  logic [Y_BITS-1:0] y_next;
  logic              tmo;
  logic              pop;
  logic              last_beat;
  logic              last_burst;
  logic              fetch_bank;

  assign start_ok   = (state == IDLE) && line_start && calib_done;
  assign y_next     = (y_coord == Y_BITS'(SCREEN_LINES - 1)) ? '0 : y_coord + Y_BITS'(1);
  assign tmo        = (state == READ) && (timer == T_W'(WAIT_TIMEOUT));
  assign pop        = (state == READ) && mem_rd_en;
  assign last_beat  = (beat_cnt == 6'(BURST_WORDS - 1));
  assign last_burst = (burst_idx == BI_W'(NUM_BURSTS - 1));
  assign fetch_bank = y_fetch[0];

  assign mem_cmd_instr = 3'b001;
  assign mem_cmd_bl    = 6'(BURST_WORDS - 1);
  // At CMD time word_cnt == burst_idx*BURST_WORDS, so the word count doubles as the burst byte offset.
  assign mem_cmd_byte_addr = {GFX_PREFIX, y_fetch, word_cnt, 2'b00};

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:  if (start_ok) state_n = mem_rd_empty ? CMD : FLUSH;
      FLUSH: if (mem_rd_empty) state_n = CMD;
      CMD:   if (!mem_cmd_full) state_n = READ;
      READ: begin
        if (tmo)                   state_n = IDLE;
        else if (pop && last_beat) state_n = last_burst ? IDLE : CMD;
      end
      default: state_n = IDLE;
    endcase
  end

  // Pops are suppressed on the abort cycle so no word is lost between timeout and the next FLUSH.
  always_comb begin
    mem_cmd_en = 1'b0;
    mem_rd_en  = 1'b0;
    case (state)
      FLUSH:   mem_rd_en  = !mem_rd_empty;
      CMD:     mem_cmd_en = !mem_cmd_full;
      READ:    mem_rd_en  = !mem_rd_empty && !tmo;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rgb         <= 8'h00;
      underflow   <= 1'b0;
      overrun     <= 1'b0;
      timeout_err <= 1'b0;
      bank_valid  <= 2'b00;
      y_fetch     <= '0;
      burst_idx   <= '0;
      word_cnt    <= '0;
      beat_cnt    <= '0;
      timer       <= '0;
    end else begin
      if (bank_valid[y_coord[0]]) begin
        rgb <= ram[y_coord[0]][x_coord];
      end else begin
        rgb       <= BLANK_COLOR;
        underflow <= 1'b1;
      end

      if (line_start && (state != IDLE)) overrun <= 1'b1;

      if (start_ok) begin
        y_fetch            <= y_next;
        bank_valid[y_next[0]] <= 1'b0;
        burst_idx          <= '0;
        word_cnt           <= '0;
        beat_cnt           <= '0;
      end

      if ((state == CMD) && !mem_cmd_full) begin
        timer    <= '0;
        beat_cnt <= '0;
      end

      if (state == READ) begin
        if (pop) begin
          word_cnt <= word_cnt + WC_W'(1);
          beat_cnt <= beat_cnt + 6'd1;
          timer    <= '0;
          if (last_beat) begin
            if (last_burst) bank_valid[fetch_bank] <= 1'b1;
            else            burst_idx <= burst_idx + BI_W'(1);
          end
        end else if (tmo) begin
          timeout_err <= 1'b1;
        end else begin
          timer <= timer + T_W'(1);
        end
      end
    end
  end

  // Byte 0 of each word is the lowest pixel of the group of four.
  always_ff @(posedge clk) begin
    if (pop) begin
      for (int i = 0; i < 4; i++) begin
        ram[fetch_bank][{word_cnt, 2'(i)}] <= mem_rd_data[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_vga_line_prefetch.sv
module tb_vga_line_prefetch;

  logic       clk          = 1'b0;
  logic       reset        = 1'b1;
  logic       calib_done   = 1'b1;
  logic [7:0] x_coord      = 8'h00;
  logic [7:0] y_coord      = 8'h00;
  logic       line_start   = 1'b0;
  logic       mem_cmd_full = 1'b0;

  bit         mdl_mute  = 1'b0;
  bit         mdl_clear = 1'b0;
  int         mdl_delay = 0;
  logic [7:0] mdl_key   = 8'h00;

  int n_checks = 0;
  int n_fail   = 0;
  int c0, c1;

  always #5 clk = ~clk;

  function automatic logic [31:0] mk_word(input logic [29:0] a, input logic [7:0] k);
    logic [7:0] b;
    b = a[7:0];
    return {b + 8'd3, b + 8'd2, b + 8'd1, b} ^ {4{k}};
  endfunction

  // Instance 0: default 64-word bursts, prefix 0. Instance 1: 16-word bursts, prefix 14'h0123.
  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [7:0]  rgb;
    logic        underflow, overrun, timeout_err, mem_cmd_en, mem_rd_en;
    logic [2:0]  mem_cmd_instr;
    logic [5:0]  mem_cmd_bl;
    logic [29:0] mem_cmd_byte_addr;
    logic [31:0] mem_rd_data  = 32'h0;
    logic        mem_rd_empty = 1'b1;
    logic [31:0] fifo[$];
    int          rem = 0;
    int          dly = 0;
    logic [29:0] nxt = '0;
    logic [7:0]  key = 8'h00;
    bit          s_pop = 1'b0;
    bit          s_cmd = 1'b0;
    logic [29:0] s_addr = '0;
    logic [5:0]  s_bl = '0;
    int          cmd_cnt = 0;
    int          viol = 0;
    logic [29:0] cmd_log [0:63];

    vga_line_prefetch #(
      .BURST_WORDS (g == 0 ? 64 : 16),
      .GFX_PREFIX  (g == 0 ? 14'h0000 : 14'h0123)
    ) u_dut (
      .clk               (clk),
      .reset             (reset),
      .calib_done        (calib_done),
      .x_coord           (x_coord),
      .y_coord           (y_coord),
      .line_start        (line_start),
      .rgb               (rgb),
      .underflow         (underflow),
      .overrun           (overrun),
      .timeout_err       (timeout_err),
      .mem_cmd_en        (mem_cmd_en),
      .mem_cmd_instr     (mem_cmd_instr),
      .mem_cmd_bl        (mem_cmd_bl),
      .mem_cmd_byte_addr (mem_cmd_byte_addr),
      .mem_cmd_full      (mem_cmd_full),
      .mem_rd_en         (mem_rd_en),
      .mem_rd_data       (mem_rd_data),
      .mem_rd_empty      (mem_rd_empty)
    );

    always @(posedge clk) begin
      s_pop  = mem_rd_en;
      s_cmd  = mem_cmd_en;
      s_addr = mem_cmd_byte_addr;
      s_bl   = mem_cmd_bl;
      if (mem_rd_en && mem_rd_empty) viol++;
      if (mem_cmd_en) begin
        if (cmd_cnt < 64) cmd_log[cmd_cnt] = mem_cmd_byte_addr;
        cmd_cnt++;
      end
    end

    always @(negedge clk) begin
      if (mdl_clear) begin
        fifo.delete();
        rem = 0;
      end
      if (s_pop && fifo.size() > 0) void'(fifo.pop_front());
      if (s_cmd) begin
        rem = int'(s_bl) + 1;
        nxt = s_addr;
        dly = mdl_delay;
        key = mdl_key;
      end
      if (rem > 0 && !mdl_mute) begin
        if (dly > 0) dly--;
        else begin
          fifo.push_back(mk_word(nxt, key));
          nxt = nxt + 30'd4;
          rem--;
        end
      end
      mem_rd_empty = (fifo.size() == 0);
      mem_rd_data  = (fifo.size() == 0) ? 32'h0 : fifo[0];
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_line(input logic [7:0] y);
    y_coord    = y;
    line_start = 1'b1;
    tick(1);
    line_start = 1'b0;
  endtask

  task automatic snap_cmds();
    c0 = g_dut[0].cmd_cnt;
    c1 = g_dut[1].cmd_cnt;
  endtask

  // Scans x=0..255 of line y; rgb must show pixel x one cycle after x is presented.
  task automatic scan(input logic [7:0] y, input logic [7:0] k, input bit blank, input string tag);
    logic [7:0] e;
    y_coord = y;
    for (int x = 0; x < 256; x++) begin
      x_coord = 8'(x);
      tick(1);
      e = blank ? 8'h00 : (8'(x) ^ k);
      check($sformatf("%s b64 x=%0d", tag, x), {24'h0, g_dut[0].rgb}, {24'h0, e});
      check($sformatf("%s b16 x=%0d", tag, x), {24'h0, g_dut[1].rgb}, {24'h0, e});
    end
  endtask

  initial begin
    // Reset values
    reset = 1'b1;
    tick(3);
    check("rst rgb",       {24'h0, g_dut[0].rgb}, 32'h0);
    check("rst underflow", {31'h0, g_dut[0].underflow}, 32'h0);
    check("rst overrun",   {31'h0, g_dut[0].overrun}, 32'h0);
    check("rst timeout",   {31'h0, g_dut[0].timeout_err}, 32'h0);
    check("rst cmd_en",    {31'h0, g_dut[0].mem_cmd_en}, 32'h0);
    check("rst rd_en",     {31'h0, g_dut[0].mem_rd_en}, 32'h0);
    check("rst rgb b16",   {24'h0, g_dut[1].rgb}, 32'h0);
    reset = 1'b0;
    tick(2);
    check("instr",   {29'h0, g_dut[0].mem_cmd_instr}, 32'h1);
    check("bl b64",  {26'h0, g_dut[0].mem_cmd_bl}, 32'd63);
    check("bl b16",  {26'h0, g_dut[1].mem_cmd_bl}, 32'd15);

    // Basic fetch of line 6 while line 5 is displayed
    snap_cmds();
    start_line(8'd5);
    tick(120);
    check("t1 cmds b64", g_dut[0].cmd_cnt - c0, 1);
    check("t1 cmds b16", g_dut[1].cmd_cnt - c1, 4);
    check("t1 addr b64", {2'b0, g_dut[0].cmd_log[c0]}, 32'h0000_0600);
    for (int k = 0; k < 4; k++)
      check($sformatf("t1 addr b16 #%0d", k), {2'b0, g_dut[1].cmd_log[c1 + k]}, 32'h0123_0600 + 32'(k * 64));
    scan(8'd6, 8'h00, 1'b0, "t1 line6");
    x_coord = 8'h37;
    tick(1);
    check("t1 latency", {24'h0, g_dut[0].rgb}, 32'h37);

    // Bank stays invalid until the last word of the last burst
    mdl_key = 8'h5A;
    start_line(8'd5);
    y_coord = 8'd6;
    x_coord = 8'd3;
    tick(60);
    check("t2 mid b64", {24'h0, g_dut[0].rgb}, 32'h00);
    check("t2 mid b16", {24'h0, g_dut[1].rgb}, 32'h00);
    tick(40);
    check("t2 done b64", {24'h0, g_dut[0].rgb}, 32'h59);
    check("t2 done b16", {24'h0, g_dut[1].rgb}, 32'h59);
    mdl_key = 8'h00;

    // Last visible line wraps to line 0
    snap_cmds();
    start_line(8'd191);
    tick(120);
    check("t3 cmds b64", g_dut[0].cmd_cnt - c0, 1);
    check("t3 addr b64", {2'b0, g_dut[0].cmd_log[c0]}, 32'h0000_0000);
    check("t3 addr b16", {2'b0, g_dut[1].cmd_log[c1]}, 32'h0123_0000);
    scan(8'd0, 8'h00, 1'b0, "t3 line0");
    check("t3 no timeout b64", {31'h0, g_dut[0].timeout_err}, 32'h0);
    check("t3 no timeout b16", {31'h0, g_dut[1].timeout_err}, 32'h0);

    // Memory never answers
    mdl_mute = 1'b1;
    snap_cmds();
    start_line(8'd5);
    tick(90);
    check("t4 early b64", {31'h0, g_dut[0].timeout_err}, 32'h0);
    check("t4 early b16", {31'h0, g_dut[1].timeout_err}, 32'h0);
    tick(30);
    check("t4 timeout b64", {31'h0, g_dut[0].timeout_err}, 32'h1);
    check("t4 timeout b16", {31'h0, g_dut[1].timeout_err}, 32'h1);
    check("t4 cmds b64", g_dut[0].cmd_cnt - c0, 1);
    check("t4 cmds b16", g_dut[1].cmd_cnt - c1, 1);
    mdl_clear = 1'b1;
    tick(2);
    mdl_clear = 1'b0;
    mdl_mute  = 1'b0;
    scan(8'd6, 8'h00, 1'b1, "t4 blank");
    check("t4 underflow b64", {31'h0, g_dut[0].underflow}, 32'h1);
    check("t4 underflow b16", {31'h0, g_dut[1].underflow}, 32'h1);
    check("t4 no overrun b64", {31'h0, g_dut[0].overrun}, 32'h0);

    // Memory not calibrated: line_start ignored
    calib_done = 1'b0;
    snap_cmds();
    start_line(8'd5);
    tick(20);
    check("calib cmds b64", g_dut[0].cmd_cnt - c0, 0);
    check("calib cmds b16", g_dut[1].cmd_cnt - c1, 0);
    check("calib overrun", {31'h0, g_dut[0].overrun}, 32'h0);
    calib_done = 1'b1;

    // Second line_start during a fetch
    snap_cmds();
    start_line(8'd5);
    tick(10);
    start_line(8'd7);
    tick(120);
    check("t5 overrun b64", {31'h0, g_dut[0].overrun}, 32'h1);
    check("t5 overrun b16", {31'h0, g_dut[1].overrun}, 32'h1);
    check("t5 cmds b64", g_dut[0].cmd_cnt - c0, 1);
    check("t5 cmds b16", g_dut[1].cmd_cnt - c1, 4);
    check("t5 addr b64", {2'b0, g_dut[0].cmd_log[c0]}, 32'h0000_0600);
    scan(8'd6, 8'h00, 1'b0, "t5 line6");

    // Reset in the middle of a fetch
    start_line(8'd5);
    tick(20);
    reset = 1'b1;
    tick(2);
    check("mrst cmd_en",  {31'h0, g_dut[0].mem_cmd_en}, 32'h0);
    check("mrst rd_en",   {31'h0, g_dut[0].mem_rd_en}, 32'h0);
    check("mrst overrun", {31'h0, g_dut[0].overrun}, 32'h0);
    check("mrst timeout", {31'h0, g_dut[1].timeout_err}, 32'h0);
    check("mrst rgb",     {24'h0, g_dut[0].rgb}, 32'h0);
    reset = 1'b0;
    tick(80);
    scan(8'd6, 8'h00, 1'b1, "mrst blank");

    // Late burst lands after a timeout; the next fetch must discard it
    mdl_delay = 120;
    mdl_key   = 8'hA5;
    start_line(8'd5);
    tick(90);
    check("t6 early b64", {31'h0, g_dut[0].timeout_err}, 32'h0);
    tick(210);
    check("t6 timeout b64", {31'h0, g_dut[0].timeout_err}, 32'h1);
    check("t6 timeout b16", {31'h0, g_dut[1].timeout_err}, 32'h1);
    mdl_delay = 0;
    mdl_key   = 8'h00;
    snap_cmds();
    start_line(8'd5);
    tick(200);
    check("t6 cmds b64", g_dut[0].cmd_cnt - c0, 1);
    check("t6 cmds b16", g_dut[1].cmd_cnt - c1, 4);
    check("t6 drained b64", {31'h0, g_dut[0].mem_rd_empty}, 32'h1);
    scan(8'd6, 8'h00, 1'b0, "t6 line6");
    check("rd_en while empty b64", g_dut[0].viol, 0);
    check("rd_en while empty b16", g_dut[1].viol, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
